// File: rtl/comb_src_sched.sv
// comb_src_sched: 3:1 source scheduler into one registered valid/ready output; round-robin, or fixed priority with COMB_SCHED_FIXED_PRIO_EN.
// Latency: req/data to out_data is 1 cycle. Backpressure: while out_valid & !out_ready nothing is granted and the output word holds.
module comb_src_sched #(
  parameter int size = 1,
  parameter int cntw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [size-1:0]   src1,
  input  logic [size-1:0]   src2,
  input  logic [size-1:0]   src3,
  output logic [2:0]        gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [size-1:0]   out_data,
  output logic [1:0]        out_src,
  output logic [3*cntw-1:0] gnt_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [cntw-1:0] CNT_ONE = {{(cntw-1){1'b0}}, 1'b1};

  state_t          state, state_nxt;
  logic [1:0]      ptr;
  logic [1:0]      win;
  logic            can_load;
  logic            capture;
  logic [size-1:0] win_data;
  logic [cntw-1:0] cnt [3];

`ifndef COMB_SCHED_FIXED_PRIO_EN
  logic [1:0] first, second;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction
`endif

  // Winner choice; when no request is pending the value is irrelevant since capture is 0.
  always_comb begin
`ifdef COMB_SCHED_FIXED_PRIO_EN
    if (req[0])      win = 2'd0;
    else if (req[1]) win = 2'd1;
    else             win = 2'd2;
`else
    first  = rr_next(ptr);
    second = rr_next(first);
    if (req[first])       win = first;
    else if (req[second]) win = second;
    else                  win = ptr;
`endif
  end

  always_comb begin
    case (win)
      2'd0:    win_data = src1;
      2'd1:    win_data = src2;
      default: win_data = src3;
    endcase
  end

  always_comb begin
    state_nxt = state;
    can_load  = 1'b0;
    case (state)
      EMPTY: begin
        can_load = 1'b1;
        if (|req) state_nxt = FULL;
      end
      FULL: begin
        can_load = out_ready;
        if (out_ready && !(|req)) state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
    capture = can_load && (|req) && !reset;
    gnt     = capture ? (3'b001 << win) : 3'b000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      ptr      <= 2'd2;
      out_data <= '0;
      out_src  <= 2'd0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        out_data <= win_data;
        out_src  <= win;
        ptr      <= win;
        if (cnt[win] != {cntw{1'b1}}) cnt[win] <= cnt[win] + CNT_ONE;
      end
    end
  end

  assign out_valid = (state == FULL);
  assign gnt_cnt   = {cnt[2], cnt[1], cnt[0]};

endmodule

// File: tb/tb_comb_src_sched.sv
// Directed + randomized bench for comb_src_sched against a rule-level reference model.
module tb_comb_src_sched;

  localparam int SIZE = 4;
  localparam int CNTW = 2;
  localparam int CMAX = (1 << CNTW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        req;
  logic [SIZE-1:0]   src1, src2, src3;
  logic [2:0]        gnt;
  logic              out_valid;
  logic              out_ready;
  logic [SIZE-1:0]   out_data;
  logic [1:0]        out_src;
  logic [3*CNTW-1:0] gnt_cnt;

  int checks = 0;
  int errors = 0;

  bit         m_valid = 0;
  int         m_data  = 0;
  int         m_src   = 0;
  int         m_ptr   = 2;
  int         m_cnt[3] = '{0, 0, 0};
  logic [2:0] obs_gnt;

  always #5 clk = ~clk;

  comb_src_sched #(.size(SIZE), .cntw(CNTW)) dut (
    .clk(clk), .reset(reset), .req(req),
    .src1(src1), .src2(src2), .src3(src3),
    .gnt(gnt), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_src(out_src), .gnt_cnt(gnt_cnt)
  );

  function automatic int pick(input logic [2:0] r);
`ifdef COMB_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (r[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check gnt before the edge, update model, check registers after.
  task automatic cycle(input logic rst, input logic [2:0] r, input logic rdy,
                       input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input logic [SIZE-1:0] c);
    int         w;
    int         srcv[3];
    logic [2:0] eg;
    @(negedge clk);
    reset = rst; req = r; out_ready = rdy; src1 = a; src2 = b; src3 = c;
    #1;
    w  = (rst || (m_valid && !rdy)) ? -1 : pick(r);
    eg = (w < 0) ? 3'b000 : 3'(1 << w);
    obs_gnt = gnt;
    chk("gnt", gnt, eg);
    @(posedge clk);
    #1;
    srcv = '{int'(a), int'(b), int'(c)};
    if (rst) begin
      m_valid = 0; m_data = 0; m_src = 0; m_ptr = 2;
      m_cnt = '{0, 0, 0};
    end else if (w >= 0) begin
      m_valid = 1; m_data = srcv[w]; m_src = w; m_ptr = w;
      if (m_cnt[w] < CMAX) m_cnt[w]++;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_src", out_src, m_src);
    chk("gnt_cnt", gnt_cnt, m_cnt[0] + (m_cnt[1] << CNTW) + (m_cnt[2] << (2 * CNTW)));
  endtask

  initial begin
    logic [2:0] one;
    one = 3'b001;
    reset = 1'b1; req = 3'b000; out_ready = 1'b0; src1 = '0; src2 = '0; src3 = '0;

    cycle(1, 3'b000, 0, 4'h0, 4'h0, 4'h0);
    cycle(1, 3'b111, 1, 4'h1, 4'h2, 4'h3);
    chk("reset_valid", out_valid, 0);
    chk("reset_cnt", gnt_cnt, 0);

    // all three requesting with a free output
    for (int i = 0; i < 6; i++) begin
      cycle(0, 3'b111, 1, 4'(i), 4'(i + 4), 4'(i + 8));
`ifdef COMB_SCHED_FIXED_PRIO_EN
      chk("t1_gnt", obs_gnt, 3'b001);
`else
      chk("t1_gnt", obs_gnt, one << (i % 3));
      chk("t1_src", out_src, i % 3);
`endif
    end

    cycle(0, 3'b000, 1, 4'h0, 4'h0, 4'h0);
    chk("drain_valid", out_valid, 0);

    // single grant then stall
    cycle(0, 3'b010, 0, 4'h1, 4'hA, 4'h2);
    chk("t2_gnt", obs_gnt, 3'b010);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 3'b010, 0, 4'h1, 4'hA, 4'h2);
      chk("t2_stall_gnt", obs_gnt, 3'b000);
      chk("t2_data", out_data, 4'hA);
      chk("t2_valid", out_valid, 1);
    end

    // drain and capture in the same cycle
    cycle(0, 3'b100, 1, 4'h0, 4'h0, 4'h5);
    chk("t3_data", out_data, 4'h5);
    chk("t3_valid", out_valid, 1);

    // counter saturation
    cycle(1, 3'b000, 0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 3'b001, 1, 4'(i), 4'h0, 4'h0);
      chk("t4_cnt0", gnt_cnt[CNTW-1:0], (i + 1 < 3) ? i + 1 : 3);
    end

    // reset while holding a word from requester 1
    cycle(0, 3'b010, 0, 4'h0, 4'h7, 4'h0);
    chk("t5_pre_valid", out_valid, 1);
    cycle(1, 3'b111, 1, 4'h0, 4'h0, 4'h0);
    chk("t5_valid", out_valid, 0);
    chk("t5_cnt", gnt_cnt, 0);
    cycle(0, 3'b111, 1, 4'h3, 4'h4, 4'h5);
    chk("t5_gnt", obs_gnt, 3'b001);

`ifdef COMB_SCHED_FIXED_PRIO_EN
    cycle(1, 3'b000, 0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 3'b111, 1, 4'h1, 4'h2, 4'h3);
      chk("t6_gnt", obs_gnt, 3'b001);
    end
    chk("t6_cnt12", gnt_cnt[3*CNTW-1:CNTW], 0);
`endif

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
            4'($urandom), 4'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
